// File: rtl/bp_cce_mem_responder.sv
// CCE-MEM memory endpoint: one command in flight, fixed-latency response.
// Optional BP_MEM_RESPONDER_BOUNDS_CHECK_EN faults addresses beyond storage.
module bp_cce_mem_responder #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 2,
    parameter int lce_assoc_p       = 8,
    parameter int dword_width_p     = 64,
    parameter int mem_els_p         = 64,
    parameter int latency_p         = 4,
    localparam int way_id_width_lp  = $clog2(lce_assoc_p),
    localparam int cce_mem_msg_width_lp =
        4 + paddr_width_p + 3 + lce_id_width_p
        + way_id_width_lp + 3 + 1 + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_ready_i
);

    localparam int lg_block_bytes_lp = $clog2(cce_block_width_p / 8);
    localparam int lg_els_lp         = $clog2(mem_els_p);
    localparam int cnt_w_lp          = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam logic [2:0] max_size_lp = 3'($clog2(dword_width_p / 8));

    localparam logic [3:0] e_cce_mem_rd    = 4'd0;
    localparam logic [3:0] e_cce_mem_wr    = 4'd1;
    localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;
    localparam logic [3:0] e_cce_mem_wb    = 4'd4;

    typedef struct packed {
        logic [lce_id_width_p-1:0]  lce_id;
        logic [way_id_width_lp-1:0] way_id;
        logic [2:0]                 state;
        logic                       speculative;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [paddr_width_p-1:0]     addr;
        logic [2:0]                   size;
        bp_cce_mem_payload_s          payload;
        logic [cce_block_width_p-1:0] data;
    } bp_cce_mem_msg_s;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_wait  = 2'd1,
        e_send  = 2'd2
    } state_e;

    state_e                       state_r, state_n;
    logic [cnt_w_lp-1:0]          cnt_r;
    bp_cce_mem_msg_s              cmd, resp_r, resp_n;
    logic [cce_block_width_p-1:0] mem_r [mem_els_p];

    logic [lg_els_lp-1:0]         idx;
    logic [lg_block_bytes_lp-1:0] offset_aligned;
    logic [2:0]                   uc_size;
    logic [dword_width_p-1:0]     dword_mask;
    logic [cce_block_width_p-1:0] blk, byte_mask;
    logic [cce_block_width_p-1:0] uc_rd_blk, uc_wr_blk;
    logic [cce_block_width_p-1:0] resp_data, wr_blk;
    logic                         is_rd, is_wr, is_uc_rd, is_uc_wr;
    logic                         oob, wr_en, accept;

    assign cmd = mem_cmd_i;
    assign idx = cmd.addr[lg_block_bytes_lp+:lg_els_lp];
    assign blk = mem_r[idx];

    assign is_rd    = cmd.msg_type == e_cce_mem_rd;
    assign is_wr    = (cmd.msg_type == e_cce_mem_wr)
                    | (cmd.msg_type == e_cce_mem_wb);
    assign is_uc_rd = cmd.msg_type == e_cce_mem_uc_rd;
    assign is_uc_wr = cmd.msg_type == e_cce_mem_uc_wr;

`ifdef BP_MEM_RESPONDER_BOUNDS_CHECK_EN
    assign oob = |cmd.addr[paddr_width_p-1:lg_block_bytes_lp+lg_els_lp];
`else
    assign oob = 1'b0;
`endif

    // Uncached sizes beyond a dword clamp; offsets round down to alignment.
    assign uc_size = (cmd.size > max_size_lp) ? max_size_lp : cmd.size;
    assign offset_aligned = cmd.addr[lg_block_bytes_lp-1:0]
                          & ({lg_block_bytes_lp{1'b1}} << uc_size);
    assign dword_mask = ~({dword_width_p{1'b1}} << (8 << uc_size));
    assign byte_mask = {{(cce_block_width_p-dword_width_p){1'b0}}, dword_mask};

    assign uc_rd_blk = (blk >> {offset_aligned, 3'b000}) & byte_mask;
    assign uc_wr_blk = (blk & ~(byte_mask << {offset_aligned, 3'b000}))
                     | ((cmd.data & byte_mask) << {offset_aligned, 3'b000});

    always_comb begin
        resp_data = '0;
        wr_en     = 1'b0;
        wr_blk    = uc_wr_blk;
        unique case (1'b1)
            is_rd:    resp_data = oob ? '1 : blk;
            is_uc_rd: resp_data = oob ? '1 : uc_rd_blk;
            is_wr: begin
                wr_en  = ~oob;
                wr_blk = cmd.data;
            end
            is_uc_wr: wr_en = ~oob;
            default: ;
        endcase
        resp_n      = cmd;
        resp_n.data = resp_data;
    end

    assign accept = (state_r == e_ready) & mem_cmd_v_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) state_r <= e_ready;
        else          state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ready: if (mem_cmd_v_i)
                state_n = (latency_p == 1) ? e_send : e_wait;
            e_wait: if (cnt_r <= cnt_w_lp'(1))
                state_n = e_send;
            e_send: if (mem_resp_ready_i)
                state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    always_comb begin
        mem_cmd_ready_o = 1'b0;
        mem_resp_v_o    = 1'b0;
        mem_resp_o      = reset_i ? resp_r : '0;
        unique case (state_r)
            e_ready: mem_cmd_ready_o = reset_i;
            e_send:  mem_resp_v_o    = reset_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_r  <= '0;
            resp_r <= '0;
            for (int i = 0; i < mem_els_p; i++) mem_r[i] <= '0;
        end else if (accept) begin
            cnt_r  <= cnt_w_lp'(latency_p - 1);
            resp_r <= resp_n;
            if (wr_en) mem_r[idx] <= wr_blk;
        end else if (state_r == e_wait && cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_cce_mem_responder.sv
// Bench for bp_cce_mem_responder: timing/data model plus directed vectors.
`timescale 1ns/1ps
module tb_bp_cce_mem_responder;

    localparam int LAT = 4;
    localparam int ELS = 64;
    localparam int MW  = 4 + 40 + 3 + 2 + 3 + 3 + 1 + 512;

    localparam logic [3:0] RD   = 4'd0;
    localparam logic [3:0] WR   = 4'd1;
    localparam logic [3:0] UCRD = 4'd2;
    localparam logic [3:0] UCWR = 4'd3;
    localparam logic [3:0] WB   = 4'd4;

    typedef struct packed {
        logic [3:0]   msg_type;
        logic [39:0]  addr;
        logic [2:0]   size;
        logic [1:0]   lce_id;
        logic [2:0]   way_id;
        logic [2:0]   state;
        logic         spec;
        logic [511:0] data;
    } msg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_v = 1'b0;
    logic resp_rdy = 1'b1;
    logic cmd_rdy, resp_v;
    msg_t cmd, resp;

    int tests = 0;
    int fails = 0;

    bp_cce_mem_responder #(.mem_els_p(ELS), .latency_p(LAT)) dut (
        .clk_i(clk),
        .reset_i(rst_n),
        .mem_cmd_i(cmd),
        .mem_cmd_v_i(cmd_v),
        .mem_cmd_ready_o(cmd_rdy),
        .mem_resp_o(resp),
        .mem_resp_v_o(resp_v),
        .mem_resp_ready_i(resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [MW-1:0] got,
                       input logic [MW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Model: a flat byte-addressable block store and one pending response.
    logic [511:0] mdl_mem [ELS];
    int   cyc = 0;
    int   acc = 0;
    logic pending = 1'b0;
    msg_t exp_r = '0;

    function automatic bit out_of_range(logic [39:0] a);
`ifdef BP_MEM_RESPONDER_BOUNDS_CHECK_EN
        return a[39:12] != '0;
`else
        return a[39:39] === 1'bx;
`endif
    endfunction

    function automatic int nbytes(logic [2:0] sz);
        return 1 << ((sz > 3'd3) ? 3 : int'(sz));
    endfunction

    function automatic msg_t expect_resp(msg_t c);
        msg_t r = c;
        logic [511:0] b = mdl_mem[c.addr[11:6]];
        int n = nbytes(c.size);
        int off = int'(c.addr[5:0]);
        int a = off - (off % n);
        r.data = '0;
        if (c.msg_type == RD)
            r.data = out_of_range(c.addr) ? '1 : b;
        else if (c.msg_type == UCRD) begin
            if (out_of_range(c.addr)) r.data = '1;
            else for (int i = 0; i < n; i++) r.data[8*i +: 8] = b[8*(a+i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [511:0] new_block(msg_t c);
        logic [511:0] b = mdl_mem[c.addr[11:6]];
        int n = nbytes(c.size);
        int off = int'(c.addr[5:0]);
        int a = off - (off % n);
        if (out_of_range(c.addr)) return b;
        if (c.msg_type == WR || c.msg_type == WB) b = c.data;
        else if (c.msg_type == UCWR)
            for (int i = 0; i < n; i++) b[8*(a+i) +: 8] = c.data[8*i +: 8];
        return b;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            pending <= 1'b0;
            exp_r   <= '0;
            for (int i = 0; i < ELS; i++) mdl_mem[i] <= '0;
        end else if (pending) begin
            if (cyc >= acc + LAT && resp_rdy) pending <= 1'b0;
        end else if (cmd_v) begin
            pending <= 1'b1;
            acc     <= cyc;
            exp_r   <= expect_resp(cmd);
            mdl_mem[cmd.addr[11:6]] <= new_block(cmd);
        end
    end

    wire exp_v   = rst_n && pending && (cyc >= acc + LAT);
    wire exp_rdy = rst_n && !pending;

    always @(negedge clk) begin
        chk("cmd_ready", MW'(cmd_rdy), MW'(exp_rdy));
        chk("resp_v", MW'(resp_v), MW'(exp_v));
        if (exp_v) chk("resp_msg", resp, exp_r);
        else if (!rst_n) chk("resp_in_reset", resp, '0);
    end

    function automatic msg_t mk(logic [3:0] t, logic [39:0] a,
                                logic [2:0] sz, logic [511:0] d);
        msg_t m = '0;
        m.msg_type = t;
        m.addr = a;
        m.size = sz;
        m.data = d;
        return m;
    endfunction

    task automatic send(input msg_t m, output int t0);
        int k = 0;
        @(negedge clk);
        while (!cmd_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_rdy) chk("send_timeout", MW'(0), MW'(1));
        #1;
        cmd = m;
        cmd_v = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        cmd_v = 1'b0;
        cmd = '0;
    endtask

    task automatic get_resp(input string nm, input logic [511:0] want,
                            input int t0, input int hold, output msg_t got);
        int k = 0;
        got = '0;
        @(negedge clk);
        while (!resp_v && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!resp_v) begin
            chk({nm, "_timeout"}, MW'(0), MW'(1));
            return;
        end
        chk({nm, "_lat"}, MW'(cyc - t0), MW'(LAT));
        chk({nm, "_data"}, MW'(resp.data), MW'(want));
        chk({nm, "_model"}, MW'(exp_r.data), MW'(want));
        got = resp;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk({nm, "_held"}, MW'(resp.data), MW'(want));
        #1 resp_rdy = 1'b1;
        @(posedge clk);
        #1;
    endtask

    msg_t m, g;
    int   t0;

    initial begin
        cmd = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", MW'(cmd_rdy), MW'(1));
        chk("idle_resp_v", MW'(resp_v), MW'(0));

        m = mk(RD, 40'h0, 3'd6, '0);
        m.lce_id = 2'd2;
        m.way_id = 3'd5;
        m.state = 3'd3;
        m.spec = 1'b1;
        send(m, t0);
        get_resp("rd0", '0, t0, 0, g);
        chk("rd0_hdr", MW'({g.msg_type, g.addr, g.lce_id, g.way_id, g.state, g.spec}),
            MW'({RD, 40'h0, 2'd2, 3'd5, 3'd3, 1'b1}));

        send(mk(WR, 40'h40, 3'd6, {64{8'hA5}}), t0);
        get_resp("wr40", '0, t0, 0, g);
        send(mk(RD, 40'h40, 3'd6, '0), t0);
        get_resp("rd40", {64{8'hA5}}, t0, 0, g);
        chk("rd40_type", MW'(g.msg_type), MW'(RD));

        send(mk(WR, 40'h0, 3'd6, '0), t0);
        get_resp("wr0", '0, t0, 0, g);
        send(mk(UCWR, 40'h4, 3'd2, 512'h11223344_DEADBEEF), t0);
        get_resp("ucwr4", '0, t0, 0, g);
        send(mk(UCRD, 40'h0, 3'd3, '0), t0);
        get_resp("ucrd8", 512'hDEADBEEF_00000000, t0, 0, g);
        send(mk(UCRD, 40'h7, 3'd0, '0), t0);
        get_resp("ucrd1", 512'hDE, t0, 0, g);
        send(mk(UCRD, 40'h6, 3'd2, '0), t0);
        get_resp("ucrd4_mis", 512'hDEADBEEF, t0, 0, g);
        send(mk(UCRD, 40'h5, 3'd1, '0), t0);
        get_resp("ucrd2_mis", 512'hBEEF, t0, 0, g);

        #1 resp_rdy = 1'b0;
        send(mk(RD, 40'h40, 3'd6, '0), t0);
        get_resp("hold", {64{8'hA5}}, t0, 10, g);
        @(negedge clk);
        chk("hold_after_ready", MW'(cmd_rdy), MW'(1));

        send(mk(WR, 40'h1040, 3'd6, {64{8'h5A}}), t0);
        get_resp("wr1040", '0, t0, 0, g);
        send(mk(RD, 40'h1040, 3'd6, '0), t0);
`ifdef BP_MEM_RESPONDER_BOUNDS_CHECK_EN
        get_resp("rd1040", {512{1'b1}}, t0, 0, g);
        send(mk(RD, 40'h40, 3'd6, '0), t0);
        get_resp("rd40_kept", {64{8'hA5}}, t0, 0, g);
`else
        get_resp("rd1040", {64{8'h5A}}, t0, 0, g);
        send(mk(RD, 40'h40, 3'd6, '0), t0);
        get_resp("rd40_wrap", {64{8'h5A}}, t0, 0, g);
`endif

        send(mk(RD, 40'h40, 3'd6, '0), t0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_v", MW'(resp_v), MW'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", MW'(cmd_rdy), MW'(1));
        send(mk(RD, 40'h40, 3'd6, '0), t0);
        get_resp("rd40_cleared", '0, t0, 0, g);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
